// File: rtl/sqr6_sweep_ctrl_if.sv
// Sequencer-side handshake and result bus of the 6-input exhaustive sweep controller.
interface sqr6_sweep_ctrl_if;
  logic        start;
  logic        abort;
  logic        busy;
  logic        done;
  logic        pass;
  logic [63:0] tt;
  logic [6:0]  mis_cnt;
  logic [5:0]  first_mis;
  logic [15:0] sig;

  modport master (
    output start, abort,
    input  busy, done, pass, tt, mis_cnt, first_mis, sig
  );

  modport slave (
    input  start, abort,
    output busy, done, pass, tt, mis_cnt, first_mis, sig
  );
endinterface

// File: rtl/sqr6_sweep_ctrl.sv
// Exhaustive 64-vector sweep of a 6-in/1-out function, compared against GOLDEN_TT.
// Define SQR6_SWEEP_MISR_EN to build the 16-bit MISR signature on sig; otherwise sig is 0.
//
// state    | meaning
// S_IDLE   | waiting for start; x0..x5 hold the last vector
// S_SETTLE | vector driven, settle timer running
// S_SAMPLE | y0 captured and compared, advance or finish
// S_DONE   | one-cycle done pulse, pass valid
module sqr6_sweep_ctrl #(
  parameter logic [63:0] GOLDEN_TT     = 64'h0,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  sqr6_sweep_ctrl_if.slave   bus,
  output logic               x0,
  output logic               x1,
  output logic               x2,
  output logic               x3,
  output logic               x4,
  output logic               x5,
  input  logic               y0
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [7:0] SCNT_LOAD = 8'(SETTLE_CYCLES - 1);

  state_t      state, state_nxt;
  logic [5:0]  vec;
  logic [7:0]  scnt;
  logic [63:0] tt;
  logic [6:0]  mis_cnt;
  logic [5:0]  first_mis;
  logic        pass;

  logic start_acc;
  logic abort_any;
  logic sample_en;
  logic mis;
  logic last_vec;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start_acc = 1'b0;
    abort_any = 1'b0;
    sample_en = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          start_acc = 1'b1;
          state_nxt = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (bus.abort) begin
          abort_any = 1'b1;
          state_nxt = S_IDLE;
        end else if (scnt == 8'd0) begin
          state_nxt = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        if (bus.abort) begin
          abort_any = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          sample_en = 1'b1;
          state_nxt = last_vec ? S_DONE : S_SETTLE;
        end
      end
      S_DONE: begin
        abort_any = bus.abort;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign mis      = (y0 != GOLDEN_TT[vec]);
  assign last_vec = (vec == 6'd63);

  // Settle timer counts down from SETTLE_CYCLES-1; SAMPLE follows terminal count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec  <= 6'd0;
      scnt <= 8'd0;
    end else if (start_acc) begin
      vec  <= 6'd0;
      scnt <= SCNT_LOAD;
    end else if (state == S_SETTLE && !bus.abort && scnt != 8'd0) begin
      scnt <= scnt - 8'd1;
    end else if (sample_en && !last_vec) begin
      vec  <= vec + 6'd1;
      scnt <= SCNT_LOAD;
    end
  end

  // pass is resolved on the final sample so it is already valid while done is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tt        <= 64'h0;
      mis_cnt   <= 7'd0;
      first_mis <= 6'd0;
      pass      <= 1'b0;
    end else if (start_acc) begin
      tt        <= 64'h0;
      mis_cnt   <= 7'd0;
      first_mis <= 6'd0;
      pass      <= 1'b0;
    end else if (abort_any) begin
      pass <= 1'b0;
    end else if (sample_en) begin
      tt[vec] <= y0;
      if (mis) begin
        mis_cnt <= mis_cnt + 7'd1;
        if (mis_cnt == 7'd0) first_mis <= vec;
      end
      if (last_vec) pass <= (mis_cnt == 7'd0) && !mis;
    end
  end

`ifdef SQR6_SWEEP_MISR_EN
  logic [15:0] misr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misr <= 16'h0000;
    end else if (start_acc) begin
      misr <= 16'hFFFF;
    end else if (sample_en) begin
      misr <= {misr[14:0], 1'b0} ^ (misr[15] ? 16'h1021 : 16'h0000) ^ {15'b0, y0};
    end
  end

  assign bus.sig = misr;
`else
  assign bus.sig = 16'h0000;
`endif

  assign {x5, x4, x3, x2, x1, x0} = vec;
  assign bus.busy      = (state == S_SETTLE) || (state == S_SAMPLE);
  assign bus.done      = (state == S_DONE);
  assign bus.pass      = pass;
  assign bus.tt        = tt;
  assign bus.mis_cnt   = mis_cnt;
  assign bus.first_mis = first_mis;

endmodule

// File: tb/tb_sqr6_sweep_ctrl.sv
// Directed bench: three controllers with different golden tables share one y0 model
// (x0 or x5&x4); sweep timing, results, abort, start-while-busy and reset are checked.
module tb_sqr6_sweep_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   mode;
  int   n_vec = 0;
  int   n_mis = 0;

  always #5 clk = ~clk;

  sqr6_sweep_ctrl_if bus_a ();
  sqr6_sweep_ctrl_if bus_b ();
  sqr6_sweep_ctrl_if bus_c ();

  logic [5:0] xa, xb, xc;
  logic       ya, yb, yc;

  assign ya = (mode == 0) ? xa[0] : (xa[5] & xa[4]);
  assign yb = (mode == 0) ? xb[0] : (xb[5] & xb[4]);
  assign yc = (mode == 0) ? xc[0] : (xc[5] & xc[4]);

  sqr6_sweep_ctrl #(.GOLDEN_TT(64'hAAAA_AAAA_AAAA_AAAA), .SETTLE_CYCLES(2)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a),
    .x0(xa[0]), .x1(xa[1]), .x2(xa[2]), .x3(xa[3]), .x4(xa[4]), .x5(xa[5]), .y0(ya)
  );

  sqr6_sweep_ctrl #(.GOLDEN_TT(64'h0), .SETTLE_CYCLES(2)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b),
    .x0(xb[0]), .x1(xb[1]), .x2(xb[2]), .x3(xb[3]), .x4(xb[4]), .x5(xb[5]), .y0(yb)
  );

  sqr6_sweep_ctrl #(.GOLDEN_TT(64'hAAAA_AAAA_AAAA_AAAB), .SETTLE_CYCLES(2)) dut_c (
    .clk(clk), .rst(rst), .bus(bus_c),
    .x0(xc[0]), .x1(xc[1]), .x2(xc[2]), .x3(xc[3]), .x4(xc[4]), .x5(xc[5]), .y0(yc)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_sig(input logic [63:0] t);
    logic [15:0] s;
    s = 16'h0000;
`ifdef SQR6_SWEEP_MISR_EN
    s = 16'hFFFF;
    for (int i = 0; i < 64; i++)
      s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {15'b0, t[i]};
`endif
    return s;
  endfunction

  task automatic set_ctl(input logic s, input logic a);
    bus_a.start = s; bus_a.abort = a;
    bus_b.start = s; bus_b.abort = a;
    bus_c.start = s; bus_c.abort = a;
  endtask

  // Called at a negedge with the DUTs idle; returns at the negedge where done is seen.
  task automatic run_sweep(input int m, input int stray_start, output int done_cyc);
    mode = m;
    set_ctl(1'b1, 1'b0);
    @(negedge clk);
    set_ctl(1'b0, 1'b0);
    chk("busy_rise", 64'(bus_a.busy), 64'd1);
    done_cyc = -1;
    for (int c = 1; c <= 300; c++) begin
      if (bus_a.done) begin
        done_cyc = c;
        break;
      end
      set_ctl(c == stray_start, 1'b0);
      @(negedge clk);
    end
    set_ctl(1'b0, 1'b0);
  endtask

  int dcyc;
  int seen;

  initial begin
    mode = 0;
    rst  = 1'b1;
    set_ctl(1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(bus_a.busy), 64'd0);
    chk("rst_done", 64'(bus_a.done), 64'd0);
    chk("rst_x",    64'(xa), 64'd0);
    chk("rst_tt",   bus_a.tt, 64'd0);
    chk("rst_sig",  64'(bus_a.sig), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // y0 = x0, with a stray start at cycle 50
    run_sweep(0, 50, dcyc);
    chk("m0_done_cycle", 64'(dcyc), 64'd193);
    chk("m0_b_done",     64'(bus_b.done), 64'd1);
    chk("m0_busy_low",   64'(bus_a.busy), 64'd0);
    chk("m0_x_last",     64'(xa), 64'd63);
    chk("m0_a_tt",       bus_a.tt, 64'hAAAA_AAAA_AAAA_AAAA);
    chk("m0_a_pass",     64'(bus_a.pass), 64'd1);
    chk("m0_a_mis",      64'(bus_a.mis_cnt), 64'd0);
    chk("m0_a_sig",      64'(bus_a.sig), 64'(exp_sig(64'hAAAA_AAAA_AAAA_AAAA)));
    chk("m0_b_mis",      64'(bus_b.mis_cnt), 64'd32);
    chk("m0_b_first",    64'(bus_b.first_mis), 64'd1);
    chk("m0_b_pass",     64'(bus_b.pass), 64'd0);
    chk("m0_c_pass",     64'(bus_c.pass), 64'd0);
    chk("m0_c_mis",      64'(bus_c.mis_cnt), 64'd1);
    chk("m0_c_first",    64'(bus_c.first_mis), 64'd0);
    @(negedge clk);
    chk("m0_done_pulse", 64'(bus_a.done), 64'd0);
    chk("m0_pass_held",  64'(bus_a.pass), 64'd1);
    chk("m0_x_held",     64'(xa), 64'd63);

    // y0 = x5 & x4, started back-to-back in the cycle after done
    run_sweep(1, 0, dcyc);
    chk("m1_done_cycle", 64'(dcyc), 64'd193);
    chk("m1_b_tt",       bus_b.tt, 64'hFFFF_0000_0000_0000);
    chk("m1_b_mis",      64'(bus_b.mis_cnt), 64'd16);
    chk("m1_b_first",    64'(bus_b.first_mis), 64'd48);
    chk("m1_b_pass",     64'(bus_b.pass), 64'd0);
    chk("m1_a_mis",      64'(bus_a.mis_cnt), 64'd32);
    chk("m1_a_first",    64'(bus_a.first_mis), 64'd1);
    chk("m1_a_sig",      64'(bus_a.sig), 64'(exp_sig(64'hFFFF_0000_0000_0000)));
    chk("m1_c_mis",      64'(bus_c.mis_cnt), 64'd33);
    chk("m1_c_first",    64'(bus_c.first_mis), 64'd0);
    @(negedge clk);

    // start and abort together in IDLE: abort wins
    set_ctl(1'b1, 1'b1);
    @(negedge clk);
    set_ctl(1'b0, 1'b0);
    chk("start_abort_idle", 64'(bus_a.busy), 64'd0);
    @(negedge clk);
    chk("start_abort_idle2", 64'(bus_a.busy), 64'd0);

    // abort at vector 10 with y0 = x0
    mode = 0;
    set_ctl(1'b1, 1'b0);
    @(negedge clk);
    set_ctl(1'b0, 1'b0);
    for (int k = 0; k < 100; k++) begin
      if (xa == 6'd10) break;
      @(negedge clk);
    end
    chk("abort_reach_vec", 64'(xa), 64'd10);
    set_ctl(1'b0, 1'b1);
    @(negedge clk);
    set_ctl(1'b0, 1'b0);
    chk("abort_busy", 64'(bus_a.busy), 64'd0);
    chk("abort_pass", 64'(bus_a.pass), 64'd0);
    chk("abort_x_held", 64'(xa), 64'd10);
    chk("abort_a_tt", bus_a.tt, 64'h0000_0000_0000_02AA);
    chk("abort_b_mis", 64'(bus_b.mis_cnt), 64'd5);
    seen = 0;
    for (int k = 0; k < 250; k++) begin
      if (bus_a.done || bus_a.busy) seen++;
      @(negedge clk);
    end
    chk("abort_no_done", 64'(seen), 64'd0);

    // reset asserted at vector 20
    set_ctl(1'b1, 1'b0);
    @(negedge clk);
    set_ctl(1'b0, 1'b0);
    for (int k = 0; k < 200; k++) begin
      if (xa == 6'd20) break;
      @(negedge clk);
    end
    chk("rst_reach_vec", 64'(xa), 64'd20);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_busy",  64'(bus_a.busy), 64'd0);
    chk("mrst_done",  64'(bus_a.done), 64'd0);
    chk("mrst_x",     64'(xa), 64'd0);
    chk("mrst_tt",    bus_a.tt, 64'd0);
    chk("mrst_b_mis", 64'(bus_b.mis_cnt), 64'd0);
    chk("mrst_first", 64'(bus_b.first_mis), 64'd0);
    chk("mrst_sig",   64'(bus_a.sig), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 220; k++) begin
      if (bus_a.done || bus_a.busy) seen++;
      @(negedge clk);
    end
    chk("mrst_no_done", 64'(seen), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
